// File: rtl/distortion_shaper.sv
// Three-stage pre-gain + waveshaper (bypass / hard / soft / asymmetric clip) for signed PCM.
// Define DIST_CLIP_CNT_EN to build the saturating clip-event counter; otherwise clip_count_o is 0.
module distortion_shaper #(
   parameter int DATA_W = 24,
   parameter int GAIN_W = 8,
   parameter int FRAC_W = 4,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   input  logic [DATA_W-1:0] sample_in_i,
   input  logic              cfg_load_i,
   input  logic [1:0]        cfg_mode_i,
   input  logic [GAIN_W-1:0] cfg_gain_i,
   input  logic [DATA_W-2:0] cfg_thresh_i,
   output logic              out_valid_o,
   output logic [DATA_W-1:0] sample_out_o,
   output logic              clip_out_o,
   input  logic              clip_clr_i,
   output logic [CNT_W-1:0]  clip_count_o
);

   localparam int PW = DATA_W + GAIN_W - FRAC_W + 1;
   localparam int MW = DATA_W + GAIN_W + 1;

   logic [1:0]        mode_q;
   logic [GAIN_W-1:0] gain_q;
   logic [DATA_W-2:0] thr_q;

   logic                     v1_q;
   logic signed [DATA_W-1:0] x1_q;
   logic [1:0]               mode1_q;
   logic [GAIN_W-1:0]        gain1_q;
   logic [DATA_W-2:0]        thr1_q;

   logic                     v2_q;
   logic signed [DATA_W-1:0] x2_q;
   logic [1:0]               mode2_q;
   logic [DATA_W-2:0]        thr2_q;
   logic signed [PW-1:0]     p2_q;

   logic                     out_valid_q;
   logic [DATA_W-1:0]        y_q;
   logic                     clip_q;

   logic signed [MW-1:0]     prod;
   logic signed [PW-1:0]     p_d;
   logic [DATA_W-1:0]        y_d;
   logic                     clip_d;
   logic                     neg;
   logic [PW-1:0]            mag, t_ext, k_ext, soft_raw, soft_lim;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mode_q <= 2'd0;
         gain_q <= GAIN_W'(1 << FRAC_W);
         thr_q  <= '1;
      end else if (cfg_load_i) begin
         mode_q <= cfg_mode_i;
         gain_q <= cfg_gain_i;
         thr_q  <= cfg_thresh_i;
      end
   end

   // Gain is unsigned, so widen it with a zero MSB before the signed multiply.
   assign prod = x1_q * $signed({1'b0, gain1_q});
   assign p_d  = PW'(prod >>> FRAC_W);

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         v1_q    <= 1'b0;
         x1_q    <= '0;
         mode1_q <= 2'd0;
         gain1_q <= '0;
         thr1_q  <= '0;
         v2_q    <= 1'b0;
         x2_q    <= '0;
         mode2_q <= 2'd0;
         thr2_q  <= '0;
         p2_q    <= '0;
      end else begin
         v1_q <= in_valid_i;
         if (in_valid_i) begin
            x1_q    <= $signed(sample_in_i);
            mode1_q <= mode_q;
            gain1_q <= gain_q;
            thr1_q  <= thr_q;
         end
         v2_q <= v1_q;
         if (v1_q) begin
            x2_q    <= x1_q;
            mode2_q <= mode1_q;
            thr2_q  <= thr1_q;
            p2_q    <= p_d;
         end
      end
   end

   always_comb begin
      neg      = p2_q[PW-1];
      mag      = neg ? $unsigned(-p2_q) : $unsigned(p2_q);
      t_ext    = PW'(thr2_q);
      k_ext    = t_ext >> 1;
      soft_raw = k_ext + ((mag - k_ext) >> 2);
      soft_lim = (soft_raw > t_ext) ? t_ext : soft_raw;
      y_d      = DATA_W'(p2_q);
      clip_d   = 1'b0;
      case (mode2_q)
         2'd0: y_d = x2_q;
         2'd1: begin
            if (mag > t_ext) begin
               clip_d = 1'b1;
               y_d    = neg ? -DATA_W'(t_ext) : DATA_W'(t_ext);
            end
         end
         2'd2: begin
            if (mag > k_ext) begin
               clip_d = 1'b1;
               y_d    = neg ? -DATA_W'(soft_lim) : DATA_W'(soft_lim);
            end
         end
         default: begin
            // Asymmetric: negative half clamps at half the positive threshold.
            if (!neg && (mag > t_ext)) begin
               clip_d = 1'b1;
               y_d    = DATA_W'(t_ext);
            end else if (neg && (mag > k_ext)) begin
               clip_d = 1'b1;
               y_d    = -DATA_W'(k_ext);
            end
         end
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         out_valid_q <= 1'b0;
         y_q         <= '0;
         clip_q      <= 1'b0;
      end else begin
         out_valid_q <= v2_q;
         if (v2_q) begin
            y_q    <= y_d;
            clip_q <= clip_d;
         end
      end
   end

   assign out_valid_o  = out_valid_q;
   assign sample_out_o = y_q;
   assign clip_out_o   = clip_q;

`ifdef DIST_CLIP_CNT_EN
   logic [CNT_W-1:0] cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clip_clr_i) begin
         cnt_q <= '0;
      end else if (out_valid_q && clip_q && (cnt_q != '1)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign clip_count_o = cnt_q;
`else
   logic unused_clip_clr;
   assign unused_clip_clr = clip_clr_i;
   assign clip_count_o    = '0;
`endif

endmodule

// File: tb/tb_distortion_shaper.sv
// Directed + randomized bench for distortion_shaper against an arithmetic reference model.
module tb_distortion_shaper;
   localparam int DATA_W = 24;
   localparam int GAIN_W = 8;
   localparam int FRAC_W = 4;
   localparam int CNT_W  = 16;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              rst = 1'b1, in_valid = 1'b0, cfg_load = 1'b0, clip_clr = 1'b0;
   logic [DATA_W-1:0] sample_in = '0;
   logic [1:0]        cfg_mode = 2'd0;
   logic [GAIN_W-1:0] cfg_gain = 8'd16;
   logic [DATA_W-2:0] cfg_thresh = '0;
   logic              out_valid, clip_out;
   logic [DATA_W-1:0] sample_out;
   logic [CNT_W-1:0]  clip_count;

   distortion_shaper #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC_W(FRAC_W), .CNT_W(CNT_W)) dut (
      .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .sample_in_i(sample_in),
      .cfg_load_i(cfg_load), .cfg_mode_i(cfg_mode), .cfg_gain_i(cfg_gain),
      .cfg_thresh_i(cfg_thresh), .out_valid_o(out_valid), .sample_out_o(sample_out),
      .clip_out_o(clip_out), .clip_clr_i(clip_clr), .clip_count_o(clip_count)
   );

   int checks = 0, failures = 0;

   typedef struct {
      int     due;
      longint y;
      bit     c;
      bit     has_dir;
      longint dy;
      bit     dc;
   } ent_t;
   ent_t q[$];

   int     ecnt = 0;
   longint m_mode = 0, m_gain = 16, m_thr = 0;
   longint last_y = 0, cnt_m = 0;
   bit     last_c = 1'b0, cur_ov = 1'b0;
   bit     dir_has = 1'b0, dir_c = 1'b0;
   longint dir_y = 0;

   function automatic void shape(input longint x, input longint mode, input longint gain,
                                 input longint thr, output longint y, output bit c);
      longint p, a, k, m;
      p = (x * gain) >>> FRAC_W;
      a = (p < 0) ? -p : p;
      k = thr / 2;
      c = 1'b0;
      y = p;
      case (mode)
         0: y = x;
         1: if (a > thr) begin c = 1'b1; y = (p < 0) ? -thr : thr; end
         2: if (a > k) begin
               c = 1'b1;
               m = k + (a - k) / 4;
               if (m > thr) m = thr;
               y = (p < 0) ? -m : m;
            end
         default: if (p > thr) begin c = 1'b1; y = thr; end
                  else if (p < -k) begin c = 1'b1; y = -k; end
      endcase
   endfunction

   task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] e);
      checks++;
      assert (obs === e) else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, e);
      end
   endtask

   task automatic tick();
      ent_t   e;
      longint y, nc;
      bit     c;
      nc = cnt_m;
`ifdef DIST_CLIP_CNT_EN
      if (clip_clr) nc = 0;
      else if (cur_ov && last_c && cnt_m < (1 << CNT_W) - 1) nc = cnt_m + 1;
`endif
      if (rst) begin
         q.delete();
         m_mode = 0;
         m_gain = 1 << FRAC_W;
         m_thr  = (1 << (DATA_W - 1)) - 1;
         nc     = 0;
      end else begin
         if (in_valid) begin
            shape(longint'($signed(sample_in)), m_mode, m_gain, m_thr, y, c);
            e.due = ecnt + 3; e.y = y; e.c = c;
            e.has_dir = dir_has; e.dy = dir_y; e.dc = dir_c;
            q.push_back(e);
         end
         if (cfg_load) begin
            m_mode = longint'(cfg_mode);
            m_gain = longint'(cfg_gain);
            m_thr  = longint'(cfg_thresh);
         end
      end
      dir_has = 1'b0;
      @(posedge clk);
      #1;
      ecnt++;
      cnt_m = nc;
      if (rst) begin last_y = 0; last_c = 1'b0; end
      cur_ov = 1'b0;
      if (q.size() > 0 && q[0].due == ecnt) begin
         e = q.pop_front();
         cur_ov = 1'b1;
         last_y = e.y;
         last_c = e.c;
         if (e.has_dir) begin
            chk("dir_sample", $signed(sample_out), e.dy);
            chk("dir_clip", clip_out, e.dc);
         end
      end
      chk("out_valid", out_valid, cur_ov);
      chk("sample_out", $signed(sample_out), last_y);
      chk("clip_out", clip_out, last_c);
      chk("clip_count", clip_count, cnt_m);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic send(input longint x, input bit hd, input longint dy, input bit dc);
      in_valid  = 1'b1;
      sample_in = DATA_W'(x);
      dir_has   = hd;
      dir_y     = dy;
      dir_c     = dc;
      tick();
      in_valid  = 1'b0;
   endtask

   task automatic cfg(input int mode, input int gain, input int thr);
      cfg_mode   = 2'(mode);
      cfg_gain   = GAIN_W'(gain);
      cfg_thresh = (DATA_W-1)'(thr);
      cfg_load   = 1'b1;
      tick();
      cfg_load   = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      idle(2);
      chk("rst_valid", out_valid, 0);
      chk("rst_sample", sample_out, 0);
      chk("rst_clip", clip_out, 0);
      chk("rst_count", clip_count, 0);
      rst = 1'b0;

      send(120, 1'b1, 120, 1'b0);
      idle(3);

      cfg(1, 32, 100);
      send(40, 1'b1, 80, 1'b0);
      send(60, 1'b1, 100, 1'b1);
      send(-60, 1'b1, -100, 1'b1);
      idle(3);

      cfg(2, 16, 100);
      send(80, 1'b1, 57, 1'b1);
      send(300, 1'b1, 100, 1'b1);
      send(-80, 1'b1, -57, 1'b1);
      send(50, 1'b1, 50, 1'b0);
      idle(3);

      cfg(3, 16, 100);
      send(150, 1'b1, 100, 1'b1);
      send(-150, 1'b1, -50, 1'b1);
      send(-40, 1'b1, -40, 1'b0);
      idle(3);

      cfg(1, 16, 50);
      send(60, 1'b1, 50, 1'b1);
      send(60, 1'b1, 50, 1'b1);
      cfg_mode = 2'd0;
      cfg_load = 1'b1;
      send(60, 1'b1, 50, 1'b1);
      cfg_load = 1'b0;
      send(60, 1'b1, 60, 1'b0);
      idle(4);

      cfg(0, 16, 0);
      send(77, 1'b1, 77, 1'b0);
      cfg(1, 16, 0);
      send(5, 1'b1, 0, 1'b1);
      send(0, 1'b1, 0, 1'b0);
      cfg(3, 0, 100);
      send(-9999, 1'b1, 0, 1'b0);
      idle(4);

      clip_clr = 1'b1;
      idle(1);
      clip_clr = 1'b0;
      cfg(1, 16, 50);
      for (int i = 0; i < 5; i++) send(60, 1'b1, 50, 1'b1);
      idle(4);
`ifdef DIST_CLIP_CNT_EN
      chk("count_five", clip_count, 5);
`else
      chk("count_off", clip_count, 0);
`endif
      send(60, 1'b0, 0, 1'b0);
      send(60, 1'b0, 0, 1'b0);
      rst = 1'b1;
      idle(1);
      rst = 1'b0;
      idle(4);
      chk("count_after_rst", clip_count, 0);

      cfg(1, 16, 50);
      for (int i = 0; i < 3; i++) send(60, 1'b1, 50, 1'b1);
      clip_clr = 1'b1;
      idle(3);
      clip_clr = 1'b0;
      idle(2);
      chk("count_after_clr", clip_count, 0);

      for (int i = 0; i < 600; i++) begin
         rst      = ($urandom_range(0, 99) == 0);
         in_valid = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 1) == 1) sample_in = DATA_W'($urandom);
         else sample_in = DATA_W'(int'($urandom_range(0, 800)) - 400);
         cfg_load = ($urandom_range(0, 7) == 0);
         cfg_mode = 2'($urandom);
         cfg_gain = ($urandom_range(0, 5) == 0) ? '0 : GAIN_W'($urandom);
         case ($urandom_range(0, 3))
            0:       cfg_thresh = '0;
            1:       cfg_thresh = (DATA_W-1)'($urandom_range(0, 400));
            2:       cfg_thresh = '1;
            default: cfg_thresh = (DATA_W-1)'($urandom);
         endcase
         clip_clr = ($urandom_range(0, 19) == 0);
         tick();
      end
      rst = 1'b0; in_valid = 1'b0; cfg_load = 1'b0; clip_clr = 1'b0;
      idle(5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/distortion_shaper.md
Name: distortion_shaper

Overview:
- Parametrised successor to the single-mode `distortion` block in the guitar-pedal audio path.
- Takes signed PCM samples with a valid strobe and applies pre-gain.
- Then applies one of four runtime-selectable waveshaping modes: bypass, hard clip, soft clip or asymmetric clip.
- Emits shaped samples after a fixed 3-cycle pipeline with a per-sample clip flag.

Parameters:
- DATA_W, 24, sample width (signed two's complement)
- GAIN_W, 8, unsigned pre-gain width
- FRAC_W, 4, fractional bits of gain (gain value 1<<FRAC_W = 1.0)
- CNT_W, 16, clip-counter width (used only with the optional feature)

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  sample_in valid this cycle; may be high every cycle
- sample_in  in  DATA_W  signed input sample
- cfg_load  in  1  load cfg_* into the active config registers
- cfg_mode  in  2  0 bypass, 1 hard, 2 soft, 3 asymmetric
- cfg_gain  in  GAIN_W  unsigned pre-gain, Q(GAIN_W-FRAC_W).FRAC_W
- cfg_thresh  in  DATA_W-1  unsigned clip threshold T
- out_valid  out  1  sample_out/clip_out valid
- sample_out  out  DATA_W  signed shaped sample
- clip_out  out  1  shaping altered this sample
- clip_clr  in  1  clear clip_count
- clip_count  out  CNT_W  saturating clip-event count

Behaviour:
- Reset (rst=1 at a clk edge):
  - out_valid=0, sample_out=0, clip_out=0, clip_count=0.
  - Pipeline valid bits cleared; in-flight samples are discarded.
  - Active config set to mode=0, gain=1<<FRAC_W, T=2^(DATA_W-1)-1.
- Config:
  - On a cfg_load edge, the active registers take cfg_* values, effective from the next cycle.
  - Each accepted sample snapshots the active config into stage 1 and carries it down the pipe.
  - Changing config therefore never affects samples already in flight.
  - cfg_load in the same cycle as in_valid: that sample uses the OLD config.
- Pipeline (no backpressure, latency exactly 3 cycles from in_valid to out_valid):
  - S1: register x=sample_in plus the config snapshot.
  - S2: p = (x * gain) >>> FRAC_W.
    - Signed multiply, arithmetic shift (floor), full width DATA_W+GAIN_W-FRAC_W+1.
    - No truncation before shaping.
  - S3: shaping plus output register.
- Shaping, with K = T>>1 and a = |p|; result y takes the sign of p:
  - mode 0: y = x (ungained, same latency); clip_out=0.
  - mode 1: y = clamp(p, -T, +T); clip_out = (a > T).
  - mode 2: if a<=K then y=p; else |y| = min(T, K + ((a-K)>>2)). clip_out = (a > K).
  - mode 3: positive p clamped to +T, negative p clamped to -K. clip_out when either clamp is active.
- Width and boundaries:
  - T<=2^(DATA_W-1)-1, so y always fits DATA_W.
  - Negative clamp is -T, never -2^(DATA_W-1).
  - T=0: modes 1-3 output 0, with clip_out=1 for any nonzero p.
  - gain=0: p=0, output 0, clip_out=0.
- Output timing:
  - When out_valid=0, sample_out and clip_out hold their last values.
  - clip_out is qualified by out_valid.

Optional Feature:
- DIST_CLIP_CNT_EN defined:
  - clip_count increments by 1 on each cycle with out_valid & clip_out.
  - Saturates at 2^CNT_W-1.
  - clip_clr clears it to 0; clip_clr wins over a simultaneous increment.
- DIST_CLIP_CNT_EN undefined:
  - No counter logic; clip_count tied to 0 and clip_clr ignored.
  - Port list unchanged.

Test Plan:
- Reset then bypass: rst high 2 cycles, all outputs 0. in 120 at cycle t -> out_valid and sample_out=120 at t+3, clip_out=0.
- Hard clip, gain=32 (2.0), T=100, back-to-back inputs 40, 60, -60:
  - outputs 80 (clip=0), 100 (clip=1), -100 (clip=1) on 3 consecutive cycles.
- Soft clip, gain=16, T=100 (K=50), inputs 80, 300, -80, 50:
  - outputs 57, 100, -57, 50.
  - clip_out 1, 1, 1, 0.
- Asymmetric, gain=16, T=100, inputs 150, -150, -40:
  - outputs 100, -50, -40.
  - clip_out 1, 1, 0.
- Config timing:
  - Streaming 60 in mode 1 (gain 16, T=50), pulse cfg_load to mode 0 in the same cycle as a sample.
  - That sample -> 50; next sample -> 60.
- Reset mid-stream plus counter (DIST_CLIP_CNT_EN):
  - 5 clipped samples -> clip_count=5.
  - rst asserted with 2 samples in flight -> no out_valid afterwards, count=0.
  - clip_clr during a clipped output -> count=0.
